// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with 2-bit counters, EX mispredict check,
// optional hit/total stats under macro BRANCH_PREDICTOR_STAT_EN.
// Ports: clk, rstn (sync, active-low), stall; IF lookup pc_IF ->
// pred_taken_IF/pred_pc_IF; EX resolve upd_* and pred_pc_EX ->
// mispredict_EX/correct_pc_EX; stats hit_cnt/tot_cnt (0 when macro undefined).
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic [XLEN-1:0] pc_IF,
  output logic            pred_taken_IF,
  output logic [XLEN-1:0] pred_pc_IF,
  input  logic            upd_valid_EX,
  input  logic [XLEN-1:0] upd_pc_EX,
  input  logic            upd_taken_EX,
  input  logic [XLEN-1:0] upd_target_EX,
  input  logic [XLEN-1:0] pred_pc_EX,
  output logic            mispredict_EX,
  output logic [XLEN-1:0] correct_pc_EX,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     tot_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_en;
  logic [1:0]       ctr_d;
  logic [XLEN-1:0]  actual;

  assign lk_idx = pc_IF[IDX_W+1:2];
  assign lk_tag = pc_IF[XLEN-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign pred_taken_IF = lk_hit && ctr_q[lk_idx][1];
  assign pred_pc_IF    = pred_taken_IF ? tgt_q[lk_idx]
                                       : pc_IF + XLEN'(4);

  assign actual        = upd_taken_EX ? upd_target_EX
                                      : upd_pc_EX + XLEN'(4);
  assign correct_pc_EX = actual;
  assign mispredict_EX = upd_valid_EX && (actual != pred_pc_EX);

  assign up_idx = upd_pc_EX[IDX_W+1:2];
  assign up_tag = upd_pc_EX[XLEN-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_en  = upd_valid_EX && !stall;

  always_comb begin
    ctr_d = ctr_q[up_idx];
    if (!up_hit)
      ctr_d = 2'b10;
    else if (upd_taken_EX && ctr_q[up_idx] != 2'b11)
      ctr_d = ctr_q[up_idx] + 2'd1;
    else if (!upd_taken_EX && ctr_q[up_idx] != 2'b00)
      ctr_d = ctr_q[up_idx] - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (up_en && (up_hit || upd_taken_EX)) begin
      // a not-taken miss leaves the entry alone
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      ctr_q[up_idx]   <= ctr_d;
      if (upd_taken_EX)
        tgt_q[up_idx] <= upd_target_EX;
    end
  end

`ifdef BRANCH_PREDICTOR_STAT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] tot_cnt_q, tot_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    tot_cnt_d = tot_cnt_q;
    if (up_en) begin
      tot_cnt_d = tot_cnt_q + 32'd1;
      if (!mispredict_EX)
        hit_cnt_d = hit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_cnt_q <= '0;
      tot_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      tot_cnt_q <= tot_cnt_d;
    end
  end

  assign hit_cnt = hit_cnt_q;
  assign tot_cnt = tot_cnt_q;
`else
  assign hit_cnt = 32'd0;
  assign tot_cnt = 32'd0;
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: BTB/BHT entry count, power of two, 2..256.
REQ-002 SHALL have parameter XLEN, default 32: PC and target width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port stall  input  1: pipeline freeze; blocks all state updates.
REQ-006 SHALL have port pc_IF  input  XLEN: fetch PC to look up.
REQ-007 SHALL have port pred_taken_IF  output  1: prediction for pc_IF is taken.
REQ-008 SHALL have port pred_pc_IF  output  XLEN: predicted next fetch PC.
REQ-009 SHALL have port upd_valid_EX  input  1: control-transfer instruction (branch/jal/jalr) resolved in EX this cycle.
REQ-010 SHALL have port upd_pc_EX  input  XLEN: PC of the resolved instruction.
REQ-011 SHALL have port upd_taken_EX  input  1: actual outcome of the resolved instruction.
REQ-012 SHALL have port upd_target_EX  input  XLEN: actual taken target.
REQ-013 SHALL have port pred_pc_EX  input  XLEN: pred_pc_IF value carried down the pipe with the instruction.
REQ-014 SHALL have port mispredict_EX  output  1: flush request for IF/ID and ID/EX.
REQ-015 SHALL have port correct_pc_EX  output  XLEN: redirect PC when mispredict_EX=1.
REQ-016 SHALL have port hit_cnt  output  32: correct-prediction count.
REQ-017 SHALL have port tot_cnt  output  32: resolved-instruction count.

Function
REQ-018 SHALL, per entry, hold valid, tag, target (XLEN) and a 2-bit saturating counter.
REQ-019 SHALL index with pc[IDX_W+1:2] (IDX_W=log2 ENTRIES) and tag with pc[XLEN-1:IDX_W+2].
REQ-020 SHALL compute lookup combinationally, zero latency: hit = valid && tag match; pred_taken_IF = hit && ctr[1]; pred_pc_IF = pred_taken_IF ? target : pc_IF+4, wrapping modulo 2^XLEN.
REQ-021 SHALL compute actual = upd_taken_EX ? upd_target_EX : upd_pc_EX+4; mispredict_EX = upd_valid_EX && (actual != pred_pc_EX); correct_pc_EX = actual; both combinational.
REQ-022 SHALL drive mispredict_EX=0 whenever upd_valid_EX=0, regardless of stall.
REQ-023 SHALL, on an edge with upd_valid_EX=1, stall=0 and a tag hit, increment the counter (saturate at 3) if taken or decrement it (saturate at 0) if not taken, and overwrite the target only when taken.
REQ-024 SHALL, on a tag miss with taken=1, allocate: valid=1, new tag, target, counter=2'b10; this replaces any previous entry at that index.
REQ-025 SHALL, on a tag miss with taken=0, leave the entry unchanged.
REQ-026 SHALL show pre-update contents to a same-cycle lookup of the index being updated; the new contents are visible from the next cycle.
REQ-027 SHALL perform no update and no statistics increment while stall=1.

Reset
REQ-028 SHALL, on an edge with rstn=0, clear every valid bit, set every counter to 2'b01, and zero hit_cnt/tot_cnt, overriding stall and any concurrent update.
REQ-029 SHALL, after reset, predict not-taken (pred_pc_IF = pc_IF+4) for every PC.
REQ-030 SHALL leave the output state of an update that is pending while rstn=0 discarded, with no effect after reset releases.

Configuration
REQ-031 SHALL, with macro BRANCH_PREDICTOR_STAT_EN defined: increment tot_cnt on each edge with upd_valid_EX=1 and stall=0, and also increment hit_cnt on that edge when mispredict_EX=0; both counters wrap at 2^32.
REQ-032 SHALL, without BRANCH_PREDICTOR_STAT_EN: tie hit_cnt/tot_cnt to 0, instantiate no statistics registers, and keep the port list unchanged.

Verification
REQ-033 SHALL check: after reset, pc_IF=0x100 -> pred_taken_IF=0, pred_pc_IF=0x104.
REQ-034 SHALL check: update pc=0x100 taken target=0x80 with pred_pc_EX=0x104 -> mispredict_EX=1, correct_pc_EX=0x80; next cycle pc_IF=0x100 -> pred_taken_IF=1, pred_pc_IF=0x80.
REQ-035 SHALL check: two not-taken updates to pc=0x100 after allocation -> counter 10→01→00, pred_pc_IF=0x104; four taken updates -> saturates at 11, still predicts 0x80.
REQ-036 SHALL check: ENTRIES=16, allocate pc=0x100 then taken pc=0x140 (same index, different tag) -> lookup 0x100 misses (0x104), lookup 0x140 predicts its target.
REQ-037 SHALL check: update asserted with stall=1 -> table and counters unchanged, mispredict_EX still reflects the compare; rstn=0 concurrent with an update -> table cleared.
REQ-038 SHALL check, with STAT_EN: 10 updates, 3 mispredicted -> tot_cnt=10, hit_cnt=7; without STAT_EN both read 0.
